// File: rtl/mac_seg_rx_deframer.sv
// Intel MAC segmented RX stream to MFB deframer, one 8-byte MFB region per MAC segment.
// Define MAC_SEG_RX_STATS_EN to build the saturating STAT_* counters; otherwise they read 0.
module mac_seg_rx_deframer #(
    parameter int SEGMENTS      = 4,
    parameter int MAX_FRAME_LEN = 16383,
    parameter int LEN_WIDTH     = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SEGMENTS*64-1:0] rx_mac_data,
    input  logic [SEGMENTS-1:0]    rx_mac_inframe,
    input  logic [SEGMENTS*3-1:0]  rx_mac_eop_empty,
    input  logic [SEGMENTS-1:0]    rx_mac_fcs_error,
    input  logic [SEGMENTS*2-1:0]  rx_mac_error,
    input  logic                   rx_mac_valid,
    output logic [SEGMENTS*64-1:0] tx_mfb_data,
    output logic [SEGMENTS-1:0]    tx_mfb_sof,
    output logic [SEGMENTS-1:0]    tx_mfb_eof,
    output logic [SEGMENTS*3-1:0]  tx_mfb_eof_pos,
    output logic [SEGMENTS-1:0]    tx_mfb_error,
    output logic                   tx_mfb_src_rdy,
    output logic [CNT_WIDTH-1:0]   stat_frames,
    output logic [CNT_WIDTH-1:0]   stat_err_frames,
    output logic [CNT_WIDTH-1:0]   stat_oversize
);

    typedef enum logic [1:0] {HUNT, IDLE, FRAME} state_t;

    localparam logic [31:0] MAX_LEN = MAX_FRAME_LEN;

    state_t                state, state_nxt;
    logic                  prev_inframe;
    logic                  prev;
    logic [LEN_WIDTH-1:0]  len, len_nxt, final_len;
    logic [LEN_WIDTH:0]    len_ext;
    logic [SEGMENTS-1:0]   sof_c, eof_c, err_c, over_c;
    logic [SEGMENTS*3-1:0] eof_pos_c;
    logic                  emit_c;

    // The FSM walks all segments of the word in order within one cycle.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        state_nxt = state;
        len_nxt   = len;
        prev      = prev_inframe;
        sof_c     = '0;
        eof_c     = '0;
        err_c     = '0;
        over_c    = '0;
        eof_pos_c = '0;
        emit_c    = 1'b0;
        len_ext   = '0;
        final_len = '0;
        for (int i = 0; i < SEGMENTS; i++) begin
            unique case (state_nxt)
                HUNT: begin
                    if (!rx_mac_inframe[i]) state_nxt = IDLE;
                end
                IDLE: begin
                    if (rx_mac_inframe[i] && !prev) begin
                        sof_c[i]  = 1'b1;
                        emit_c    = 1'b1;
                        len_nxt   = LEN_WIDTH'(8);
                        state_nxt = FRAME;
                    end
                end
                FRAME: begin
                    emit_c = 1'b1;
                    if (rx_mac_inframe[i]) begin
                        len_ext = {1'b0, len_nxt} + (LEN_WIDTH+1)'(8);
                        len_nxt = len_ext[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : len_ext[LEN_WIDTH-1:0];
                    end else begin
                        len_ext   = {1'b0, len_nxt} + (LEN_WIDTH+1)'(8)
                                  - (LEN_WIDTH+1)'(rx_mac_eop_empty[3*i +: 3]);
                        final_len = len_ext[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : len_ext[LEN_WIDTH-1:0];
                        over_c[i] = 32'(final_len) > MAX_LEN;
                        eof_c[i]  = 1'b1;
                        eof_pos_c[3*i +: 3] = 3'd7 - rx_mac_eop_empty[3*i +: 3];
                        err_c[i]  = rx_mac_fcs_error[i] | (|rx_mac_error[2*i +: 2]) | over_c[i];
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = HUNT;
            endcase
            prev = rx_mac_inframe[i];
        end
    end

    // Idle-bus words (valid low) leave all deframing context untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HUNT;
            len          <= '0;
            prev_inframe <= 1'b1;
        end else if (rx_mac_valid) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state        <= state_nxt;
            len          <= len_nxt;
            prev_inframe <= rx_mac_inframe[SEGMENTS-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_mfb_data    <= '0;
            tx_mfb_sof     <= '0;
            tx_mfb_eof     <= '0;
            tx_mfb_eof_pos <= '0;
            tx_mfb_error   <= '0;
            tx_mfb_src_rdy <= 1'b0;
        end else begin
            tx_mfb_data    <= rx_mac_data;
            tx_mfb_sof     <= rx_mac_valid ? sof_c : '0;
            tx_mfb_eof     <= rx_mac_valid ? eof_c : '0;
            tx_mfb_eof_pos <= rx_mac_valid ? eof_pos_c : '0;
            tx_mfb_error   <= rx_mac_valid ? err_c : '0;
            tx_mfb_src_rdy <= rx_mac_valid & emit_c;
        end
    end

`ifdef MAC_SEG_RX_STATS_EN
    localparam int CW = $clog2(SEGMENTS + 1);

    logic [CW-1:0] n_eof, n_err, n_over;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CW-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    // Several frames can end in one word, so counters step by a per-word count.
    always_comb begin
        n_eof  = '0;
        n_err  = '0;
        n_over = '0;
        for (int i = 0; i < SEGMENTS; i++) begin
            n_eof  = n_eof  + CW'(eof_c[i]);
            n_err  = n_err  + CW'(eof_c[i] & err_c[i]);
            n_over = n_over + CW'(eof_c[i] & over_c[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frames     <= '0;
            stat_err_frames <= '0;
            stat_oversize   <= '0;
        end else if (rx_mac_valid) begin
            stat_frames     <= sat_add(stat_frames, n_eof);
            stat_err_frames <= sat_add(stat_err_frames, n_err);
            stat_oversize   <= sat_add(stat_oversize, n_over);
        end
    end
`else
    assign stat_frames     = '0;
    assign stat_err_frames = '0;
    assign stat_oversize   = '0;
`endif

endmodule

// File: tb/tb_mac_seg_rx_deframer.sv
// Self-checking bench for mac_seg_rx_deframer: directed scenarios plus a randomized
// segment stream compared against a per-segment frame model of the receive rules.
module tb_mac_seg_rx_deframer;

    localparam int SEG  = 4;
    localparam int MAXL = 64;
    localparam int LW   = 16;
    localparam int CW   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [SEG*64-1:0] rx_mac_data;
    logic [SEG-1:0]    rx_mac_inframe;
    logic [SEG*3-1:0]  rx_mac_eop_empty;
    logic [SEG-1:0]    rx_mac_fcs_error;
    logic [SEG*2-1:0]  rx_mac_error;
    logic              rx_mac_valid;
    logic [SEG*64-1:0] tx_mfb_data;
    logic [SEG-1:0]    tx_mfb_sof;
    logic [SEG-1:0]    tx_mfb_eof;
    logic [SEG*3-1:0]  tx_mfb_eof_pos;
    logic [SEG-1:0]    tx_mfb_error;
    logic              tx_mfb_src_rdy;
    logic [CW-1:0]     stat_frames;
    logic [CW-1:0]     stat_err_frames;
    logic [CW-1:0]     stat_oversize;

    mac_seg_rx_deframer #(
        .SEGMENTS(SEG), .MAX_FRAME_LEN(MAXL), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_mac_data(rx_mac_data), .rx_mac_inframe(rx_mac_inframe),
        .rx_mac_eop_empty(rx_mac_eop_empty), .rx_mac_fcs_error(rx_mac_fcs_error),
        .rx_mac_error(rx_mac_error), .rx_mac_valid(rx_mac_valid),
        .tx_mfb_data(tx_mfb_data), .tx_mfb_sof(tx_mfb_sof), .tx_mfb_eof(tx_mfb_eof),
        .tx_mfb_eof_pos(tx_mfb_eof_pos), .tx_mfb_error(tx_mfb_error),
        .tx_mfb_src_rdy(tx_mfb_src_rdy), .stat_frames(stat_frames),
        .stat_err_frames(stat_err_frames), .stat_oversize(stat_oversize)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: frame boundaries are edges of the in-frame flag once a gap has been seen.
    bit m_synced, m_prev, m_open;
    int m_segs, m_frames, m_err, m_over;

    logic [SEG-1:0]    e_sof, e_eof, e_err;
    logic [SEG*3-1:0]  e_pos, pos_mask;
    logic              e_rdy;
    logic [SEG*64-1:0] e_data;

    function automatic int stat_exp(input int v);
`ifdef MAC_SEG_RX_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_synced = 1'b0; m_prev = 1'b1; m_open = 1'b0;
        m_segs = 0; m_frames = 0; m_err = 0; m_over = 0;
    endtask

    task automatic model_word(input logic v, input logic [SEG-1:0] inf,
                              input logic [SEG*3-1:0] emp, input logic [SEG-1:0] fcs,
                              input logic [SEG*2-1:0] er);
        e_sof = '0; e_eof = '0; e_err = '0; e_pos = '0; e_rdy = 1'b0; pos_mask = '0;
        if (v) begin
            for (int i = 0; i < SEG; i++) begin
                bit cur = inf[i];
                if (m_open) begin
                    e_rdy = 1'b1;
                    if (cur) begin
                        m_segs++;
                    end else begin
                        int  empty = int'(emp[3*i +: 3]);
                        int  flen  = m_segs * 8 + 8 - empty;
                        bit  over  = flen > MAXL;
                        bit  bad   = fcs[i] || (er[2*i +: 2] != 2'b00) || over;
                        e_eof[i] = 1'b1;
                        e_err[i] = bad;
                        e_pos[3*i +: 3] = 3'(7 - empty);
                        m_frames++;
                        if (bad)  m_err++;
                        if (over) m_over++;
                        m_open = 1'b0;
                    end
                end else if (m_synced && cur && !m_prev) begin
                    e_sof[i] = 1'b1;
                    e_rdy    = 1'b1;
                    m_open   = 1'b1;
                    m_segs   = 1;
                end
                if (!cur) m_synced = 1'b1;
                m_prev = cur;
            end
        end
        for (int i = 0; i < SEG; i++) pos_mask[3*i +: 3] = {3{e_eof[i]}};
    endtask

    // Drives one word at the falling edge and returns one falling edge later.
    task automatic step(input logic v, input logic [SEG-1:0] inf,
                        input logic [SEG*3-1:0] emp = '0, input logic [SEG-1:0] fcs = '0,
                        input logic [SEG*2-1:0] er = '0);
        logic [SEG*64-1:0] d;
        for (int k = 0; k < SEG*2; k++) d[32*k +: 32] = $urandom();
        rx_mac_valid = v; rx_mac_inframe = inf; rx_mac_eop_empty = emp;
        rx_mac_fcs_error = fcs; rx_mac_error = er; rx_mac_data = d;
        e_data = d;
        model_word(v, inf, emp, fcs, er);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        rx_mac_valid = 1'b0; rx_mac_inframe = '0; rx_mac_eop_empty = '0;
        rx_mac_fcs_error = '0; rx_mac_error = '0; rx_mac_data = '0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (tx_mfb_src_rdy !== 1'b0) begin n_fail++; $display("FAIL reset src_rdy got %b want 0", tx_mfb_src_rdy); end
        n_checks++; if ({tx_mfb_sof, tx_mfb_eof, tx_mfb_error} !== '0) begin n_fail++; $display("FAIL reset sof/eof/err got %h want 0", {tx_mfb_sof, tx_mfb_eof, tx_mfb_error}); end
        n_checks++; if (tx_mfb_data !== '0) begin n_fail++; $display("FAIL reset data got %h want 0", tx_mfb_data); end
        n_checks++; if ({stat_frames, stat_err_frames, stat_oversize} !== '0) begin n_fail++; $display("FAIL reset stats got %h want 0", {stat_frames, stat_err_frames, stat_oversize}); end
        release_reset();
    endtask

    task automatic test_basic_frame();
        step(1'b1, 4'b0000);
        n_checks++; if (tx_mfb_src_rdy !== 1'b0) begin n_fail++; $display("FAIL basic idle src_rdy got %b want 0", tx_mfb_src_rdy); end
        step(1'b1, 4'b1111);
        n_checks++; if (tx_mfb_sof !== 4'b0001 || tx_mfb_src_rdy !== 1'b1) begin n_fail++; $display("FAIL basic sof got sof=%b rdy=%b want sof=0001 rdy=1", tx_mfb_sof, tx_mfb_src_rdy); end
        n_checks++; if (tx_mfb_data !== e_data) begin n_fail++; $display("FAIL basic data got %h want %h", tx_mfb_data, e_data); end
        step(1'b1, 4'b0111);
        n_checks++; if (tx_mfb_eof !== 4'b1000 || tx_mfb_sof !== 4'b0000) begin n_fail++; $display("FAIL basic eof got eof=%b sof=%b want eof=1000 sof=0000", tx_mfb_eof, tx_mfb_sof); end
        n_checks++; if (tx_mfb_eof_pos[11:9] !== 3'd7 || tx_mfb_error[3] !== 1'b0) begin n_fail++; $display("FAIL basic eof_pos/err got %0d/%b want 7/0", tx_mfb_eof_pos[11:9], tx_mfb_error[3]); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 4'b1111);
        n_checks++; if (tx_mfb_sof !== 4'b0001) begin n_fail++; $display("FAIL b2b first sof got %b want 0001", tx_mfb_sof); end
        step(1'b1, 4'b1101, 12'h018);
        n_checks++; if (tx_mfb_eof !== 4'b0010 || tx_mfb_sof !== 4'b0100) begin n_fail++; $display("FAIL b2b eof/sof got %b/%b want 0010/0100", tx_mfb_eof, tx_mfb_sof); end
        n_checks++; if (tx_mfb_eof_pos[5:3] !== 3'd4 || tx_mfb_error[1] !== 1'b0) begin n_fail++; $display("FAIL b2b eof_pos/err got %0d/%b want 4/0", tx_mfb_eof_pos[5:3], tx_mfb_error[1]); end
        step(1'b1, 4'b0000);
        n_checks++; if (tx_mfb_eof !== 4'b0001 || tx_mfb_eof_pos[2:0] !== 3'd7 || tx_mfb_error[0] !== 1'b0) begin n_fail++; $display("FAIL b2b second eof got eof=%b pos=%0d err=%b want 0001/7/0", tx_mfb_eof, tx_mfb_eof_pos[2:0], tx_mfb_error[0]); end
    endtask

    task automatic test_hunt();
        apply_reset();
        release_reset();
        for (int w = 0; w < 3; w++) begin
            step(1'b1, 4'b1111);
            n_checks++; if (tx_mfb_src_rdy !== 1'b0 || tx_mfb_sof !== 4'b0000) begin n_fail++; $display("FAIL hunt word%0d got rdy=%b sof=%b want 0/0000", w, tx_mfb_src_rdy, tx_mfb_sof); end
        end
        step(1'b1, 4'b0000);
        n_checks++; if (tx_mfb_src_rdy !== 1'b0 || tx_mfb_eof !== 4'b0000) begin n_fail++; $display("FAIL hunt gap got rdy=%b eof=%b want 0/0000", tx_mfb_src_rdy, tx_mfb_eof); end
        step(1'b1, 4'b1111);
        n_checks++; if (tx_mfb_sof !== 4'b0001) begin n_fail++; $display("FAIL hunt resync sof got %b want 0001", tx_mfb_sof); end
        step(1'b1, 4'b0000);
        n_checks++; if (tx_mfb_eof !== 4'b0001 || tx_mfb_error[0] !== 1'b0) begin n_fail++; $display("FAIL hunt resync eof got eof=%b err=%b want 0001/0", tx_mfb_eof, tx_mfb_error[0]); end
    endtask

    task automatic test_errors();
        step(1'b1, 4'b1111);
        step(1'b1, 4'b0000, '0, 4'b0001);
        n_checks++; if (tx_mfb_eof !== 4'b0001 || tx_mfb_error !== 4'b0001) begin n_fail++; $display("FAIL fcs_err got eof=%b err=%b want 0001/0001", tx_mfb_eof, tx_mfb_error); end
        step(1'b1, 4'b1111);
        step(1'b1, 4'b0000, '0, '0, 8'b0000_0001);
        n_checks++; if (tx_mfb_eof !== 4'b0001 || tx_mfb_error !== 4'b0001) begin n_fail++; $display("FAIL mac_err got eof=%b err=%b want 0001/0001", tx_mfb_eof, tx_mfb_error); end
        n_checks++; if (stat_err_frames !== CW'(stat_exp(2))) begin n_fail++; $display("FAIL stat_err_frames got %0d want %0d", stat_err_frames, stat_exp(2)); end
    endtask

    task automatic test_oversize();
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        step(1'b1, 4'b0000);
        n_checks++; if (tx_mfb_eof !== 4'b0001 || tx_mfb_error !== 4'b0001) begin n_fail++; $display("FAIL oversize got eof=%b err=%b want 0001/0001", tx_mfb_eof, tx_mfb_error); end
        n_checks++; if (stat_oversize !== CW'(stat_exp(1))) begin n_fail++; $display("FAIL stat_oversize got %0d want %0d", stat_oversize, stat_exp(1)); end
    endtask

    task automatic test_bubbles();
        step(1'b1, 4'b1111);
        step(1'b0, 4'b0000, 12'hfff, 4'hf, 8'hff);
        n_checks++; if (tx_mfb_src_rdy !== 1'b0 || tx_mfb_eof !== 4'b0000) begin n_fail++; $display("FAIL bubble1 got rdy=%b eof=%b want 0/0000", tx_mfb_src_rdy, tx_mfb_eof); end
        step(1'b0, 4'b1010);
        n_checks++; if (tx_mfb_src_rdy !== 1'b0 || tx_mfb_sof !== 4'b0000) begin n_fail++; $display("FAIL bubble2 got rdy=%b sof=%b want 0/0000", tx_mfb_src_rdy, tx_mfb_sof); end
        step(1'b1, 4'b0111);
        n_checks++; if (tx_mfb_eof !== 4'b1000 || tx_mfb_error[3] !== 1'b0 || tx_mfb_src_rdy !== 1'b1) begin n_fail++; $display("FAIL bubble eof got eof=%b err=%b rdy=%b want 1000/0/1", tx_mfb_eof, tx_mfb_error[3], tx_mfb_src_rdy); end
    endtask

    task automatic test_midframe_reset();
        step(1'b1, 4'b1111);
        apply_reset();
        n_checks++; if (tx_mfb_src_rdy !== 1'b0 || tx_mfb_eof !== 4'b0000) begin n_fail++; $display("FAIL midreset got rdy=%b eof=%b want 0/0000", tx_mfb_src_rdy, tx_mfb_eof); end
        release_reset();
        step(1'b1, 4'b0011);
        n_checks++; if (tx_mfb_src_rdy !== 1'b0 || tx_mfb_eof !== 4'b0000) begin n_fail++; $display("FAIL midreset truncation got rdy=%b eof=%b want 0/0000", tx_mfb_src_rdy, tx_mfb_eof); end
    endtask

    task automatic test_random();
        bit cur = 1'b0;
        for (int w = 0; w < 400; w++) begin
            logic [SEG-1:0]   inf, fcs;
            logic [SEG*3-1:0] emp;
            logic [SEG*2-1:0] er;
            logic             v;
            for (int i = 0; i < SEG; i++) begin
                if ($urandom_range(0, 3) == 0) cur = ~cur;
                inf[i]          = cur;
                emp[3*i +: 3]   = 3'($urandom_range(0, 7));
                fcs[i]          = ($urandom_range(0, 7) == 0);
                er[2*i +: 2]    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            v = ($urandom_range(0, 6) != 0);
            step(v, inf, emp, fcs, er);
            n_checks++; if (tx_mfb_src_rdy !== e_rdy) begin n_fail++; $display("FAIL rand w%0d src_rdy got %b want %b", w, tx_mfb_src_rdy, e_rdy); end
            n_checks++; if (tx_mfb_sof !== e_sof) begin n_fail++; $display("FAIL rand w%0d sof got %b want %b", w, tx_mfb_sof, e_sof); end
            n_checks++; if (tx_mfb_eof !== e_eof) begin n_fail++; $display("FAIL rand w%0d eof got %b want %b", w, tx_mfb_eof, e_eof); end
            n_checks++; if ((tx_mfb_eof_pos & pos_mask) !== e_pos) begin n_fail++; $display("FAIL rand w%0d eof_pos got %h want %h", w, tx_mfb_eof_pos & pos_mask, e_pos); end
            n_checks++; if ((tx_mfb_error & e_eof) !== e_err) begin n_fail++; $display("FAIL rand w%0d error got %b want %b", w, tx_mfb_error & e_eof, e_err); end
            if (e_rdy) begin
                n_checks++; if (tx_mfb_data !== e_data) begin n_fail++; $display("FAIL rand w%0d data got %h want %h", w, tx_mfb_data, e_data); end
            end
        end
    endtask

    task automatic test_stats();
        n_checks++; if (stat_frames !== CW'(stat_exp(m_frames))) begin n_fail++; $display("FAIL stat_frames got %0d want %0d", stat_frames, stat_exp(m_frames)); end
        n_checks++; if (stat_err_frames !== CW'(stat_exp(m_err))) begin n_fail++; $display("FAIL stat_err_frames final got %0d want %0d", stat_err_frames, stat_exp(m_err)); end
        n_checks++; if (stat_oversize !== CW'(stat_exp(m_over))) begin n_fail++; $display("FAIL stat_oversize final got %0d want %0d", stat_oversize, stat_exp(m_over)); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_hunt();
        test_errors();
        test_oversize();
        test_bubbles();
        test_midframe_reset();
        test_random();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
